sim_monitor: RTL
================

Name: sim_monitor

Overview:
Synthesizable run-control and test-status monitor that snoops the CPU data-memory write port.
- Detects writes to a TOHOST address and latches pass/fail.
- Enforces a parametrised cycle timeout.
- Buffers console characters written to a CONSOLE address in a small FIFO.
- Sits beside the memory in top; its done/pass/halt_req outputs replace fixed-delay finish in benches and drive on-board LEDs on FPGA builds.

Parameters:
ADDR_W, 32, width of snooped address bus
DATA_W, 32, width of snooped write data (min 8)
TOHOST_ADDR, 32'h0000_03F8, word address that terminates a test
CONSOLE_ADDR, 32'h0000_03FC, word address whose low byte is a console character
TIMEOUT, 350, cycles in RUN before TIMEOUT state; 0 disables timeout
CNT_W, 32, cycle counter width
CONS_DEPTH, 8, console FIFO depth (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
mem_wr_en  in  1  data-memory write strobe, qualified on rising edge
mem_addr  in  ADDR_W  data-memory write address
mem_wdata  in  DATA_W  data-memory write data
done  out  1  test terminated (PASS, FAIL or TIMEOUT)
pass  out  1  test passed
timed_out  out  1  TIMEOUT state reached
fail_code  out  DATA_W-1  mem_wdata>>1 of the failing TOHOST write
cycle_count  out  CNT_W  cycles spent in RUN
halt_req  out  1  request CPU stall; equals done
cons_valid  out  1  console FIFO non-empty
cons_data  out  8  head of console FIFO
cons_ready  in  1  consumer accepts head when cons_valid&cons_ready
cons_dropped  out  8  saturating count of characters lost to a full FIFO

Behaviour:
- Reset is sampled only on a rising edge with reset==0. While in reset: state=RUN, cycle_count=0, fail_code=0, FIFO empty, cons_dropped=0, and all flag outputs are 0.
- States: RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are sticky until reset. All outputs are registered.
- RUN:
  - cycle_count increments by 1 per cycle and saturates at all-ones.
  - Write with mem_addr==TOHOST_ADDR and mem_wdata==1 -> PASS.
  - Write with mem_addr==TOHOST_ADDR, mem_wdata[0]==1, mem_wdata!=1 -> FAIL; fail_code<=mem_wdata[DATA_W-1:1].
  - TOHOST write with mem_wdata[0]==0 is ignored (state stays RUN).
  - Timeout: TIMEOUT!=0 and cycle_count==TIMEOUT-1 at the edge with no terminating TOHOST write -> TIMEOUT. A terminating write on that same edge wins.
- Latency: a terminating write sampled at edge N shows done=1 after edge N. cycle_count freezes at its value after edge N, which includes cycle N.
- Terminal states:
  - done=halt_req=1.
  - pass=1 only in PASS; timed_out=1 only in TIMEOUT.
  - Further TOHOST writes are ignored.
  - Console writes are ignored; the FIFO still drains.
- Address compare: full ADDR_W equality; mem_wr_en=0 never matches.

Optional Feature:
SIM_MONITOR_CONSOLE_EN
- Defined: console FIFO as follows.
  - In RUN, a write to CONSOLE_ADDR pushes mem_wdata[7:0].
  - A push to a full FIFO is dropped and cons_dropped increments (saturating at 255).
  - Pop on cons_valid&cons_ready.
  - Simultaneous push and pop when full: pop occurs, push accepted, no drop.
  - Simultaneous push and pop when empty: the pushed byte becomes head next cycle.
  - Pointers wrap modulo CONS_DEPTH.
- Undefined: no FIFO logic; cons_valid=0, cons_data=0, cons_dropped=0 constantly; cons_ready ignored.
- TOHOST and timeout logic are identical in both builds.

Test Plan:
- Reset held low 3 cycles with writes active -> done=0, cycle_count=0, cons_valid=0; releasing reset starts counting 1,2,3...
- After 10 RUN cycles, write 0x1 to 0x3F8 -> next cycle done=1, pass=1, halt_req=1, cycle_count=11; later write 0x7 to 0x3F8 leaves state unchanged.
- Write 0xB (code 5) to 0x3F8 -> done=1, pass=0, fail_code=5; write 0x4 to 0x3F8 beforehand -> ignored, still RUN.
- TIMEOUT=20, no writes -> timed_out=1 exactly after cycle_count reaches 20. Second run with 0x1 written to 0x3F8 on that same edge -> PASS, timed_out=0. TIMEOUT=0 run for 1000 cycles -> never done.
- CONSOLE_EN, CONS_DEPTH=4, cons_ready=0: write 'A'..'F' to 0x3FC -> 4 stored, cons_dropped=2. Then cons_ready=1 -> cons_data sequence 0x41,0x42,0x43,0x44, then cons_valid=0.
- CONSOLE_EN, full FIFO: push and pop on the same edge -> no drop, occupancy stays 4. Reset mid-drain -> FIFO empty and cons_dropped=0 next cycle.

Source files
------------

// File: rtl/sim_monitor.sv
// sim_monitor -- run-control and test-status monitor snooping the CPU
// data-memory write port.
//
// Watches writes to TOHOST_ADDR to latch PASS/FAIL, ends a runaway test after
// TIMEOUT cycles in RUN, and (optionally) buffers console bytes written to
// CONSOLE_ADDR in a small FIFO. done/pass/halt_req end benches and drive LEDs.
//
// Build option: define SIM_MONITOR_CONSOLE_EN to include the console FIFO.
// Without it cons_valid/cons_data/cons_dropped are tied to 0 and cons_ready
// is ignored.
//
// Ports:
//   clk          in   rising-edge system clock
//   reset        in   synchronous, active-low reset
//   mem_wr_en    in   data-memory write strobe
//   mem_addr     in   [ADDR_W]   write address
//   mem_wdata    in   [DATA_W]   write data
//   done         out  test terminated (PASS, FAIL or TIMEOUT)
//   pass         out  test passed
//   timed_out    out  TIMEOUT reached
//   fail_code    out  [DATA_W-1] mem_wdata>>1 of the failing TOHOST write
//   cycle_count  out  [CNT_W]    cycles spent in RUN (saturating)
//   halt_req     out  CPU stall request, equals done
//   cons_valid   out  console FIFO non-empty
//   cons_data    out  [8]        console FIFO head
//   cons_ready   in   consumer accepts head on cons_valid & cons_ready
//   cons_dropped out  [8]        saturating count of bytes lost to a full FIFO
module sim_monitor #(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       DATA_W       = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 32'h0000_03F8,
    parameter logic [ADDR_W-1:0] CONSOLE_ADDR = 32'h0000_03FC,
    parameter int unsigned       TIMEOUT      = 350,
    parameter int unsigned       CNT_W        = 32,
    parameter int unsigned       CONS_DEPTH   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              done,
    output logic              pass,
    output logic              timed_out,
    output logic [DATA_W-2:0] fail_code,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              halt_req,
    output logic              cons_valid,
    output logic [7:0]        cons_data,
    input  logic              cons_ready,
    output logic [7:0]        cons_dropped
);

    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-2:0]   fc_q, fc_d;
    logic                done_q, pass_q, to_q;

    logic in_run, tohost_hit, cons_hit, to_hit;

    assign in_run     = (state_q == ST_RUN);
    assign tohost_hit = mem_wr_en && (mem_addr == TOHOST_ADDR);
    assign cons_hit   = mem_wr_en && (mem_addr == CONSOLE_ADDR);
    // The count reaching TIMEOUT-1 means this edge completes the last allowed cycle.
    assign to_hit     = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fc_d    = fc_q;
        if (in_run) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_ONE;
            end
            // Even TOHOST values are ignored; a terminating write beats the timeout.
            if (tohost_hit && mem_wdata[0]) begin
                if (mem_wdata == DATA_W'(1)) begin
                    state_d = ST_PASS;
                end else begin
                    state_d = ST_FAIL;
                    fc_d    = mem_wdata[DATA_W-1:1];
                end
            end else if (to_hit) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            fc_q    <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fc_q    <= fc_d;
            done_q  <= (state_d != ST_RUN);
            pass_q  <= (state_d == ST_PASS);
            to_q    <= (state_d == ST_TIMEOUT);
        end
    end

    assign done        = done_q;
    assign halt_req    = done_q;
    assign pass        = pass_q;
    assign timed_out   = to_q;
    assign fail_code   = fc_q;
    assign cycle_count = cnt_q;

`ifdef SIM_MONITOR_CONSOLE_EN
    localparam int unsigned      PTR_W   = $clog2(CONS_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   OCC_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   OCC_MAX = (PTR_W+1)'(CONS_DEPTH);

    logic [7:0]       fifo_q [CONS_DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [PTR_W:0]   occ_q, occ_d;
    logic [7:0]       head_q, head_d, drop_q, drop_d;
    logic             valid_q, push_req, push, pop;

    always_comb begin
        pop      = valid_q && cons_ready;
        push_req = in_run && cons_hit;
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push     = push_req && ((occ_q != OCC_MAX) || pop);
        rd_d     = pop  ? rd_q + PTR_ONE : rd_q;
        wr_d     = push ? wr_q + PTR_ONE : wr_q;
        occ_d    = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + OCC_ONE;
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_ONE;
        end
        drop_d = drop_q;
        if (push_req && !push && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
        // The head is registered: when the byte written this edge lands in
        // the next head slot, the FIFO was (or became) otherwise empty.
        if (occ_d == '0) begin
            head_d = 8'h00;
        end else if (push && (wr_q == rd_d)) begin
            head_d = mem_wdata[7:0];
        end else begin
            head_d = fifo_q[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_q] <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            occ_q   <= '0;
            drop_q  <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            occ_q   <= occ_d;
            drop_q  <= drop_d;
            head_q  <= head_d;
            valid_q <= (occ_d != '0);
        end
    end

    assign cons_valid   = valid_q;
    assign cons_data    = head_q;
    assign cons_dropped = drop_q;
`else
    logic unused_cons;
    assign unused_cons  = ^{cons_ready, cons_hit};
    assign cons_valid   = 1'b0;
    assign cons_data    = 8'h00;
    assign cons_dropped = 8'h00;
`endif

endmodule
